fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It is the producer side of the IF/ID buffer interface. It owns the PC and issues word requests to instruction memory over a valid/ready request and valid response handshake. It presents {pc, instruction, valid} to the IF/ID buffer and obeys the same stall_c/flush_c controls, with a redirect target on flush.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time to
// instruction memory and presents {pc, instruction, valid} to the IF/ID buffer.
module fetch_unit #(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_c,
  input  logic                  flush_c,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_resp_data_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic                  valid_o
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  logic                  req_fire;
  logic [ADDR_WIDTH-1:0] redirect_aligned;

  // The request line is a pure decode of state, forced low while reset is held.
  assign imem_req_valid_o = (state_q == S_ISSUE) && !rst;
  assign imem_addr_o      = pc_q;
  assign req_fire         = (state_q == S_ISSUE) && imem_req_ready_i;
  assign redirect_aligned = redirect_pc_i & ~ADDR_WIDTH'(3);

  assign pc_o          = pc_out_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;

  // Next-state logic: flush outranks stall and every normal transition.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;

    if (flush_c) begin
      pc_d    = redirect_aligned;
      valid_d = 1'b0;
      instr_d = BUBBLE_INSTR;
    end

    case (state_q)
      S_ISSUE: begin
        if (flush_c) begin
          // A request accepted in the flush cycle is still owed a response,
          // which must be thrown away when it arrives.
          if (req_fire) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(4);
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush_c) begin
          if (imem_resp_valid_i) begin
            drop_d  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_ISSUE;
          end else begin
            pc_out_d = req_pc_q;
            instr_d  = imem_resp_data_i;
            valid_d  = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (flush_c) begin
          state_d = S_ISSUE;
        end else if (!stall_c) begin
          valid_d = 1'b0;
          instr_d = BUBBLE_INSTR;
          state_d = S_ISSUE;
        end
      end

      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ISSUE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      pc_out_q <= '0;
      instr_q  <= BUBBLE_INSTR;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus a few
// hand-written sequences for the multi-cycle corner cases.
module tb_fetch_unit;

  localparam logic [31:0] B = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_c;
  logic        flush_c;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall_c           (stall_c),
    .flush_c           (flush_c),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .pc_o              (pc_o),
    .instruction_o     (instruction_o),
    .valid_o           (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle and the outputs expected during that cycle.
  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        ready;
    logic        rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic f, logic [31:0] rd, logic rdy,
                              logic rv, logic [31:0] dat, logic eq, logic [31:0] ea,
                              logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.ready = rdy;
    v.rv = rv; v.rdata = dat; v.ereq = eq; v.eaddr = ea; v.evalid = ev;
    v.epc = ep; v.einstr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] rd,
                       input logic rdy, input logic rv, input logic [31:0] dat);
    rst = r; stall_c = s; flush_c = f; redirect_pc_i = rd;
    imem_req_ready_i = rdy; imem_resp_valid_i = rv; imem_resp_data_i = dat;
  endtask

  initial begin
    bit seen_valid;
    bit got_req;

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("reset: req=%0b valid=%0b pc=%08h instr=%08h", imem_req_valid_o, valid_o, pc_o, instruction_o);
    chk("reset_req_valid", 32'(imem_req_valid_o), 0);
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_pc", pc_o, 0);
    chk("reset_instr", instruction_o, B);

    // rst stall flush redir ready rv rdata | req addr valid pc instr
    tbl.push_back(mk(1,0,0,0,1,0,0,                       0,0,0,0,B));
    // sequential fetch 0x0, 0x4 with 1-cycle responses
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0000,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h0,32'hA000_0000));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h4,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0004,           0,0,0,0,B));
    // stall five cycles with pc_o=0x4 held
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,0,0,1,0,0,                     0,0,1,32'h4,32'hA000_0004));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h4,32'hA000_0004));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h8,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0008,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h8,32'hA000_0008));
    // flush in WAIT to 0x103, response two cycles later is dropped
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'hC,0,0,B));
    tbl.push_back(mk(0,0,1,32'h103,1,0,0,                 0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hDEAD_DEAD,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h100,0,0,B));
    // flush coincident with the response, redirect 0x200
    tbl.push_back(mk(0,0,1,32'h200,1,1,32'hBEEF_BEEF,     0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h200,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0200,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h200,32'hA000_0200));
    // ready low four cycles, flush to 0x40 on the second
    tbl.push_back(mk(0,0,0,0,0,0,0,                       1,32'h204,0,0,B));
    tbl.push_back(mk(0,0,1,32'h40,0,0,0,                  1,32'h204,0,0,B));
    tbl.push_back(mk(0,0,0,0,0,0,0,                       1,32'h40,0,0,B));
    tbl.push_back(mk(0,0,0,0,0,0,0,                       1,32'h40,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h40,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0040,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h40,32'hA000_0040));
    // reset in WAIT, late response after release is ignored
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h44,0,0,B));
    tbl.push_back(mk(1,0,0,0,1,0,0,                       0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,0,1,32'h0BAD_0BAD,           1,32'h0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'h0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'hA000_0000,           0,0,0,0,B));
    // flush in HOLD to 0xFFFFFFFF -> fetch 0xFFFFFFFC, next address wraps to 0
    tbl.push_back(mk(0,0,1,32'hFFFF_FFFF,1,0,0,           0,0,1,32'h0,32'hA000_0000));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       1,32'hFFFF_FFFC,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,1,32'h0000_1234,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'hFFFF_FFFC,32'h0000_1234));
    // stall while nothing is valid does not block fetch
    tbl.push_back(mk(0,1,0,0,1,0,0,                       1,32'h0,0,0,B));
    tbl.push_back(mk(0,1,0,0,1,1,32'h0000_5678,           0,0,0,0,B));
    tbl.push_back(mk(0,0,0,0,1,0,0,                       0,0,1,32'h0,32'h0000_5678));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].redir,
            tbl[i].ready, tbl[i].rv, tbl[i].rdata);
      #1;
      $display("vec %0d: req=%0b addr=%08h valid=%0b pc=%08h instr=%08h",
               i, imem_req_valid_o, imem_addr_o, valid_o, pc_o, instruction_o);
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid_o), 32'(tbl[i].ereq));
      if (tbl[i].ereq)
        chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].eaddr);
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].evalid));
      if (tbl[i].evalid)
        chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].epc);
      chk($sformatf("vec%0d_instr", i), instruction_o, tbl[i].einstr);
    end

    // Handshake completes in the flush cycle: the owed response is dropped
    // and the redirect target is fetched next.
    @(negedge clk);
    drive(0, 0, 1, 32'h300, 1, 0, 0);
    #1;
    $display("flush+accept: req=%0b addr=%08h", imem_req_valid_o, imem_addr_o);
    chk("fa_req_valid", 32'(imem_req_valid_o), 1);
    chk("fa_addr", imem_addr_o, 32'h4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
    #1;
    $display("fa response: req=%0b valid=%0b", imem_req_valid_o, valid_o);
    chk("fa_wait_req", 32'(imem_req_valid_o), 0);
    seen_valid = valid_o;
    got_req = 0;
    for (int c = 0; c < 8 && !got_req; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (valid_o) seen_valid = 1;
      if (imem_req_valid_o) got_req = 1;
    end
    $display("fa reissue: got_req=%0b addr=%08h seen_valid=%0b", got_req, imem_addr_o, seen_valid);
    chk("fa_reissue_seen", 32'(got_req), 1);
    chk("fa_reissue_addr", imem_addr_o, 32'h300);
    chk("fa_no_valid", 32'(seen_valid), 0);
    imem_req_ready_i = 1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 32'h0000_300A);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    $display("fa deliver: valid=%0b pc=%08h instr=%08h", valid_o, pc_o, instruction_o);
    chk("fa_deliver_valid", 32'(valid_o), 1);
    chk("fa_deliver_pc", pc_o, 32'h300);
    chk("fa_deliver_instr", instruction_o, 32'h0000_300A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
